fmps_write_link: RTL and testbench
==================================

FMPS_WRITE_LINK -- requirements
Module: fmps_write_link

Interface
REQ-001 SHALL have parameter HEADER_MAGIC, default 16'hB6CF, the header magic value.
REQ-002 SHALL have port auroraClk, in, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port auroraReset, in, 1, reset, synchronous and active-high.
REQ-004 SHALL have port FAstrobe, in, 1, a one-cycle fast-acquisition strobe.
REQ-005 SHALL have port channelUp, in, 1, Aurora channel up.
REQ-006 SHALL have port enable, in, 1, transmit enable.
REQ-007 SHALL have port fmpsIndex, in, INDEX_WIDTH, this node's FMPS index.
REQ-008 SHALL have port fmpsData, in, 16, the FMPS payload.
REQ-009 SHALL have ports invalidFMPS2CC and invalidCC2CC, in, 1 each, the status flags.
REQ-010 SHALL have ports TDATA (out, 32), TVALID (out, 1), TLAST (out, 1) and TREADY (in, 1), forming the AXI-stream master.
REQ-011 SHALL have port cycleCounter, out, 8, the current cycle number.
REQ-012 SHALL have port overrunCount, out, 16, the count of dropped strobes.
REQ-013 SHALL have port busy, out, 1, high whenever a packet is in flight.

Function
REQ-014 SHALL set cycleCounter to cycleCounter+1 (8-bit, wrapping 255->0) on every FAstrobe, regardless of enable or channelUp.
REQ-015 SHALL, on FAstrobe with enable=1 and channelUp=1, capture a snapshot in that cycle: {invalidFMPS2CC, invalidCC2CC, 1'b0, fmpsIndex, fmpsData, cycleCounter+1}.
REQ-016 SHALL emit each packet as exactly two words:
- Header word: [31:16]=HEADER_MAGIC, [15]=0, [14:10]=fmpsIndex, [9:0]=0, with TLAST=0.
- Data word: the snapshot, with TLAST=1.
REQ-017 SHALL implement the FSM IDLE -> HEADER -> DATA -> IDLE:
- IDLE->HEADER on a capture or on a pending snapshot.
- HEADER->DATA on TVALID&TREADY.
- DATA->IDLE, or DATA->HEADER when a snapshot is pending, on TVALID&TREADY.
REQ-018 SHALL assert TVALID in the first cycle after the capture cycle (latency 1), and hold TDATA/TLAST stable while TVALID=1 and TREADY=0.
REQ-019 SHALL keep TVALID=0 in IDLE, with TDATA=0 and TLAST=0.
REQ-020 SHALL hold one pending snapshot: a capture while busy=1 with the buffer empty fills the buffer.
REQ-021 SHALL, on a capture while busy=1 with the buffer full, drop the new snapshot and increment overrunCount, saturating at 16'hFFFF.
REQ-022 SHALL, on a capture in the same cycle as the DATA-word handshake, go directly to HEADER with the new snapshot (no idle gap); the pending buffer takes priority if it is full.
REQ-023 SHALL count an FAstrobe with channelUp=0 or enable=0 as neither sent nor overrun.
REQ-024 SHALL, when channelUp drops mid-packet, abort: TVALID=0 in the next cycle, state IDLE, pending buffer cleared.
REQ-025 SHALL let an in-flight packet and a pending snapshot complete when enable drops.
REQ-026 SHALL drive busy=1 in HEADER and DATA.

Reset
REQ-027 SHALL, with auroraReset=1, set state=IDLE, TVALID=0, TLAST=0, TDATA=0, cycleCounter=0, overrunCount=0, busy=0, pending buffer empty.
REQ-028 SHALL give reset priority over FAstrobe in the same cycle: no capture and no cycleCounter increment.
REQ-029 SHALL, on reset mid-packet, abandon the packet with TVALID=0 in the next cycle.

Structure
REQ-030 SHALL place INDEX_WIDTH (5), the field bit positions (index 14:10 and 28:24, flags 31/30, reserved 29, data 23:8, cycle 7:0) and the default header magic in shared package fmps_pkg, also used by the FMPS reader.
REQ-031 SHALL be a single module with no sub-module; the pending buffer is an inline register.

Verification
REQ-032 SHALL cover basic: TREADY=1, fmpsIndex=1, fmpsData=16'hCACA, one FAstrobe -> TDATA=32'hB6CF0400, then 32'h01CACA01 with TLAST=1, on consecutive cycles.
REQ-033 SHALL cover backpressure: TREADY toggling at 50% random -> words unchanged while stalled, exactly two beats per packet, cycle bytes 1..N in order over 10 strobes.
REQ-034 SHALL cover overrun: TREADY=0, three strobes -> first packet held, one pending, overrunCount=1; release TREADY -> two packets with cycle bytes 1,2.
REQ-035 SHALL cover the gated case: channelUp=0 for strobes 1-3, then 1 -> no TVALID, cycleCounter=3, next packet carries cycle byte 4.
REQ-036 SHALL cover abort: channelUp dropped after the header handshake -> TVALID=0 next cycle, busy=0, no data word.
REQ-037 SHALL cover wrap and reset: 256 strobes -> cycle byte wraps 255->0; auroraReset asserted with FAstrobe -> cycleCounter=0, no packet.

Source files
------------

// File: rtl/fmps_pkg.sv
// Shared FMPS field layout and link types, used by both the FMPS writer and reader.
package fmps_pkg;

    localparam int INDEX_WIDTH = 5;
    localparam logic [15:0] DEFAULT_HEADER_MAGIC = 16'hB6CF;

    // Header word index field
    localparam int HDR_INDEX_LSB = 10;
    localparam int HDR_INDEX_MSB = 14;

    // Data word fields
    localparam int FLAG_FMPS2CC_BIT = 31;
    localparam int FLAG_CC2CC_BIT   = 30;
    localparam int RESERVED_BIT     = 29;
    localparam int DATA_INDEX_LSB   = 24;
    localparam int DATA_INDEX_MSB   = 28;
    localparam int DATA_LSB         = 8;
    localparam int DATA_MSB         = 23;
    localparam int CYCLE_LSB        = 0;
    localparam int CYCLE_MSB        = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA
    } linkState_t;

    function automatic logic [31:0] makeHeader(input logic [15:0] magic,
                                               input logic [INDEX_WIDTH-1:0] index);
        logic [31:0] word;
        word = '0;
        word[31:16] = magic;
        word[HDR_INDEX_MSB:HDR_INDEX_LSB] = index;
        return word;
    endfunction

endpackage

// File: rtl/fmps_write_link.sv
// Captures an FMPS snapshot on each fast-acquisition strobe and streams it
// out as a two-word AXI-stream packet, with one snapshot of buffering.
module fmps_write_link
    import fmps_pkg::*;
#(
    parameter logic [15:0] HEADER_MAGIC = DEFAULT_HEADER_MAGIC
) (
    input  logic                   auroraClk,
    input  logic                   auroraReset,
    input  logic                   FAstrobe,
    input  logic                   channelUp,
    input  logic                   enable,
    input  logic [INDEX_WIDTH-1:0] fmpsIndex,
    input  logic [15:0]            fmpsData,
    input  logic                   invalidFMPS2CC,
    input  logic                   invalidCC2CC,
    output logic [31:0]            TDATA,
    output logic                   TVALID,
    output logic                   TLAST,
    input  logic                   TREADY,
    output logic [7:0]             cycleCounter,
    output logic [15:0]            overrunCount,
    output logic                   busy
);

    linkState_t  state, stateNext;
    logic [31:0] curSnap, curSnapNext;
    logic [31:0] pendSnap, pendSnapNext;
    logic        pendValid, pendValidNext;
    logic [31:0] newSnap;
    logic [7:0]  cycleNext;
    logic        capture, handshake, launch, overrunHit;

    assign cycleNext = cycleCounter + 8'd1;
    assign capture   = FAstrobe & enable & channelUp;
    assign handshake = TVALID & TREADY;
    // A new packet may start from IDLE or straight off the final data beat.
    assign launch    = (state == ST_IDLE) || ((state == ST_DATA) && handshake);

    always_comb begin
        newSnap = '0;
        newSnap[FLAG_FMPS2CC_BIT]               = invalidFMPS2CC;
        newSnap[FLAG_CC2CC_BIT]                 = invalidCC2CC;
        newSnap[RESERVED_BIT]                   = 1'b0;
        newSnap[DATA_INDEX_MSB:DATA_INDEX_LSB]  = fmpsIndex;
        newSnap[DATA_MSB:DATA_LSB]              = fmpsData;
        newSnap[CYCLE_MSB:CYCLE_LSB]            = cycleNext;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        stateNext     = state;
        curSnapNext   = curSnap;
        pendSnapNext  = pendSnap;
        pendValidNext = pendValid;
        overrunHit    = 1'b0;

        if (!channelUp) begin
            stateNext     = ST_IDLE;
            pendValidNext = 1'b0;
        end else if (launch) begin
            if (pendValid) begin
                stateNext     = ST_HEADER;
                curSnapNext   = pendSnap;
                pendValidNext = capture;
                if (capture) pendSnapNext = newSnap;
            end else if (capture) begin
                stateNext   = ST_HEADER;
                curSnapNext = newSnap;
            end else begin
                stateNext = ST_IDLE;
            end
        end else begin
            if ((state == ST_HEADER) && handshake) stateNext = ST_DATA;
            if (capture) begin
                if (!pendValid) begin
                    pendSnapNext  = newSnap;
                    pendValidNext = 1'b1;
                end else begin
                    overrunHit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge auroraClk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (auroraReset) begin
            state        <= ST_IDLE;
            pendValid    <= 1'b0;
            cycleCounter <= '0;
            overrunCount <= '0;
        end else begin
            state     <= stateNext;
            pendValid <= pendValidNext;
            if (FAstrobe) cycleCounter <= cycleNext;
            if (overrunHit && (overrunCount != 16'hFFFF)) overrunCount <= overrunCount + 16'd1;
        end
    end

    // NOTE: snapshot registers are only observed when state/pendValid say so, so they carry no reset.
    always_ff @(posedge auroraClk) begin
        curSnap  <= curSnapNext;
        pendSnap <= pendSnapNext;
    end

    assign TVALID = (state != ST_IDLE);
    assign busy   = (state != ST_IDLE);
    assign TLAST  = (state == ST_DATA);
    assign TDATA  = (state == ST_HEADER) ? makeHeader(HEADER_MAGIC, curSnap[DATA_INDEX_MSB:DATA_INDEX_LSB]) :
                    (state == ST_DATA)   ? curSnap : 32'h0;

endmodule

// File: tb/tb_fmps_write_link.sv
// Self-checking bench for fmps_write_link: directed tables and sequences plus
// randomized traffic against a packet-queue reference model.
module tb_fmps_write_link;

    localparam logic [15:0] MAGIC = 16'hB6CF;

    logic        auroraClk = 1'b0;
    logic        auroraReset, FAstrobe, channelUp, enable, TREADY;
    logic [4:0]  fmpsIndex;
    logic [15:0] fmpsData;
    logic        invalidFMPS2CC, invalidCC2CC;
    logic [31:0] TDATA;
    logic        TVALID, TLAST, busy;
    logic [7:0]  cycleCounter;
    logic [15:0] overrunCount;

    fmps_write_link dut (
        .auroraClk(auroraClk), .auroraReset(auroraReset), .FAstrobe(FAstrobe),
        .channelUp(channelUp), .enable(enable), .fmpsIndex(fmpsIndex), .fmpsData(fmpsData),
        .invalidFMPS2CC(invalidFMPS2CC), .invalidCC2CC(invalidCC2CC),
        .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST), .TREADY(TREADY),
        .cycleCounter(cycleCounter), .overrunCount(overrunCount), .busy(busy)
    );

    always #5 auroraClk = ~auroraClk;

    int checks = 0;
    int errors = 0;

    // Model: queue of beats still to be sent, {last, word}; occupancy = queued data words.
    logic [32:0] expQ[$];
    logic [7:0]  mCyc;
    logic [15:0] mOvr;
    logic [7:0]  rx[$];

    typedef struct {
        logic        strobe;
        logic        ready;
        logic        expValid;
        logic [31:0] expData;
        logic        expLast;
    } vec_t;

    vec_t basicVec[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compareAll();
        logic [32:0] f;
        f = (expQ.size() != 0) ? expQ[0] : 33'h0;
        check("tvalid", 32'(TVALID), 32'(expQ.size() != 0));
        check("tdata", TDATA, f[31:0]);
        check("tlast", 32'(TLAST), 32'(f[32]));
        check("busy", 32'(busy), 32'(expQ.size() != 0));
        check("cycleCounter", 32'(cycleCounter), 32'(mCyc));
        check("overrunCount", 32'(overrunCount), 32'(mOvr));
    endtask

    // One clock: inputs already driven at the negedge; model advances with the edge.
    task automatic step();
        bit hs;
        int nData;
        hs = (expQ.size() != 0) && TREADY;
        if (TVALID && TREADY && TLAST) rx.push_back(TDATA[7:0]);
        @(posedge auroraClk);
        if (auroraReset) begin
            expQ.delete();
            mCyc = 8'd0;
            mOvr = 16'd0;
        end else begin
            if (FAstrobe) mCyc = mCyc + 8'd1;
            if (hs) void'(expQ.pop_front());
            if (!channelUp) begin
                expQ.delete();
            end else if (FAstrobe && enable) begin
                nData = 0;
                foreach (expQ[i]) if (expQ[i][32]) nData++;
                if (nData < 2) begin
                    expQ.push_back({1'b0, MAGIC, 1'b0, fmpsIndex, 10'b0});
                    expQ.push_back({1'b1, invalidFMPS2CC, invalidCC2CC, 1'b0, fmpsIndex, fmpsData, mCyc});
                end else if (mOvr != 16'hFFFF) begin
                    mOvr = mOvr + 16'd1;
                end
            end
        end
        @(negedge auroraClk);
        compareAll();
    endtask

    task automatic setIdle();
        auroraReset = 1'b0; FAstrobe = 1'b0; channelUp = 1'b1; enable = 1'b1; TREADY = 1'b1;
        fmpsIndex = 5'd1; fmpsData = 16'hCACA; invalidFMPS2CC = 1'b0; invalidCC2CC = 1'b0;
    endtask

    task automatic doReset();
        setIdle();
        auroraReset = 1'b1;
        step();
        step();
        auroraReset = 1'b0;
        rx.delete();
    endtask

    task automatic drain(input bit randomReady);
        for (int k = 0; k < 200 && expQ.size() != 0; k++) begin
            TREADY = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        TREADY = 1'b1;
        step();
    endtask

    initial begin
        expQ.delete();
        mCyc = 8'd0;
        mOvr = 16'd0;
        setIdle();
        @(negedge auroraClk);
        doReset();
        check("reset_tvalid", 32'(TVALID), 32'd0);
        check("reset_tdata", TDATA, 32'd0);
        check("reset_cycle", 32'(cycleCounter), 32'd0);

        // Basic packet: header then data on consecutive cycles.
        basicVec[0] = '{1'b1, 1'b1, 1'b1, 32'hB6CF0400, 1'b0};
        basicVec[1] = '{1'b0, 1'b1, 1'b1, 32'h01CACA01, 1'b1};
        basicVec[2] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
        basicVec[3] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0};
        for (int i = 0; i < 4; i++) begin
            FAstrobe = basicVec[i].strobe;
            TREADY   = basicVec[i].ready;
            step();
            check($sformatf("basic[%0d].tvalid", i), 32'(TVALID), 32'(basicVec[i].expValid));
            check($sformatf("basic[%0d].tdata", i), TDATA, basicVec[i].expData);
            check($sformatf("basic[%0d].tlast", i), 32'(TLAST), 32'(basicVec[i].expLast));
        end

        // Backpressure: 10 spaced strobes with random TREADY.
        doReset();
        for (int i = 0; i < 10; i++) begin
            fmpsIndex = 5'($urandom); fmpsData = 16'($urandom);
            FAstrobe = 1'b1; TREADY = 1'($urandom_range(0, 1));
            step();
            FAstrobe = 1'b0;
            drain(1'b1);
        end
        check("bp_count", 32'(rx.size()), 32'd10);
        for (int i = 0; i < rx.size() && i < 10; i++)
            check($sformatf("bp_cycle[%0d]", i), 32'(rx[i]), 32'(i + 1));

        // Overrun: three strobes with TREADY low.
        doReset();
        TREADY = 1'b0; fmpsIndex = 5'd3;
        FAstrobe = 1'b1;
        step(); step(); step();
        FAstrobe = 1'b0;
        step();
        check("ovr_count", 32'(overrunCount), 32'd1);
        check("ovr_held", TDATA, 32'hB6CF0C00);
        drain(1'b0);
        check("ovr_rx_size", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            check("ovr_rx0", 32'(rx[0]), 32'd1);
            check("ovr_rx1", 32'(rx[1]), 32'd2);
        end

        // Gated strobes count cycles only.
        doReset();
        channelUp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            FAstrobe = 1'b1; step();
            FAstrobe = 1'b0; step();
            check("gate_tvalid", 32'(TVALID), 32'd0);
        end
        check("gate_cycle", 32'(cycleCounter), 32'd3);
        channelUp = 1'b1;
        FAstrobe = 1'b1; step();
        FAstrobe = 1'b0;
        drain(1'b0);
        check("gate_rx_size", 32'(rx.size()), 32'd1);
        if (rx.size() == 1) check("gate_rx0", 32'(rx[0]), 32'd4);

        // Abort after header handshake.
        doReset();
        FAstrobe = 1'b1; TREADY = 1'b1; step();
        FAstrobe = 1'b0; step();
        check("abort_in_data", 32'(TLAST), 32'd1);
        channelUp = 1'b0; TREADY = 1'b0; step();
        check("abort_tvalid", 32'(TVALID), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        channelUp = 1'b1; step(); step();
        check("abort_rx", 32'(rx.size()), 32'd0);

        // Enable drop lets in-flight and pending packets finish.
        doReset();
        TREADY = 1'b0; FAstrobe = 1'b1; step(); step();
        FAstrobe = 1'b0; enable = 1'b0;
        drain(1'b0);
        check("en_drop_rx", 32'(rx.size()), 32'd2);
        enable = 1'b1;

        // Cycle byte wrap over 256 strobes.
        doReset();
        for (int i = 0; i < 256; i++) begin
            FAstrobe = 1'b1; step();
            FAstrobe = 1'b0; step(); step();
        end
        drain(1'b0);
        check("wrap_count", 32'(rx.size()), 32'd256);
        if (rx.size() == 256) begin
            check("wrap_255", 32'(rx[254]), 32'hFF);
            check("wrap_0", 32'(rx[255]), 32'h00);
        end

        // Reset wins over a strobe, and abandons a packet mid-flight.
        FAstrobe = 1'b1; step();
        check("midpkt_cycle", 32'(cycleCounter), 32'd1);
        auroraReset = 1'b1; step();
        check("rst_strobe_cycle", 32'(cycleCounter), 32'd0);
        check("rst_strobe_tvalid", 32'(TVALID), 32'd0);
        auroraReset = 1'b0; FAstrobe = 1'b0; step();
        check("rst_no_pkt", 32'(TVALID), 32'd0);

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            auroraReset    = ($urandom_range(0, 199) == 0);
            FAstrobe       = ($urandom_range(0, 3) == 0);
            enable         = ($urandom_range(0, 9) != 0);
            channelUp      = ($urandom_range(0, 29) != 0);
            TREADY         = 1'($urandom_range(0, 1));
            fmpsIndex      = 5'($urandom);
            fmpsData       = 16'($urandom);
            invalidFMPS2CC = 1'($urandom);
            invalidCC2CC   = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
